sseg_mux_driver: RTL and testbench
==================================

// Module: sseg_mux_driver
// PURPOSE
//   Time-multiplexed driver for the 4-digit common-anode seven-segment display.
//   Drives the top-level sseg_digit/sseg_dp/sseg_selectn pins directly from a
//   16-bit hex value, per-digit decimal points and per-digit blanking.
//   New values are held in a pending register and only take effect at a frame
//   boundary, so no frame ever shows a mix of old and new digits.
//   An anode-off interval between digit slots suppresses ghosting.
// PARAMETERS
//   REFRESH_DIV   100000  clock cycles per digit slot; 1 kHz/digit at 100 MHz
//   BLANK_CYCLES  1000    cycles at the start of each slot with all anodes off
//   Legal range: BLANK_CYCLES >= 1 and REFRESH_DIV >= BLANK_CYCLES + 2.
// PORTS
//   clk           in   1   100 MHz system clock
//   rst           in   1   asynchronous active-high reset
//   disp_value    in   16  digit n shows nibble [4n+3:4n]; digit 0 is rightmost
//   disp_dp       in   4   1 = decimal point lit for digit n
//   disp_blank    in   4   1 = digit n dark (anode held off)
//   disp_load     in   1   1-cycle strobe: capture disp_value/dp/blank
//   disp_ack      out  1   1-cycle pulse: captured data now being displayed
//   frame_tick    out  1   1-cycle pulse on each digit 3 -> 0 wrap
//   sseg_digit    out  7   segments {g,f,e,d,c,b,a}, active-low
//   sseg_dp       out  1   decimal point, active-low
//   sseg_selectn  out  4   anode selects, active-low, at most one low
// BEHAVIOUR
// - Reset (asynchronous, takes effect immediately, including mid-slot):
//   - Outputs: sseg_selectn=4'hF, sseg_digit=7'h7F, sseg_dp=1, disp_ack=0,
//     frame_tick=0.
//   - State: slot counter=0, digit idx=0, state BLANK.
//   - Shadow regs: value=0, dp=0, blank=4'hF (display dark until first load).
//   - Any pending data is discarded.
// - All outputs are registered.
// - Slot counter runs 0..REFRESH_DIV-1; digit idx runs 0..3 and wraps.
// - BLANK state: selectn=4'hF, sseg_digit=7'h7F, sseg_dp=1.
// - BLANK -> DRIVE on the edge where counter==BLANK_CYCLES-1.
//   - selectn[idx]=0 unless shadow_blank[idx]=1, in which case selectn stays 4'hF.
//   - sseg_digit = decode(nibble idx); sseg_dp = ~shadow_dp[idx].
// - DRIVE -> BLANK on the edge where counter==REFRESH_DIV-1.
//   - Counter goes to 0 and idx increments.
// - Resulting timing:
//   - Each slot is BLANK_CYCLES cycles dark, then REFRESH_DIV-BLANK_CYCLES cycles lit.
//   - One frame is 4*REFRESH_DIV cycles.
// - Frame boundary is the edge where counter==REFRESH_DIV-1 and idx==3.
//   - frame_tick is high for exactly the following cycle.
// - Decode, active-low {g..a}:
//   - 0:40  1:79  2:24  3:30  4:19  5:12  6:02  7:78
//   - 8:00  9:10  A:08  b:03  C:46  d:21  E:06  F:0E
// - Load handshake:
//   - Each disp_load strobe captures the three inputs into pending regs and sets pend.
//   - Later loads before the boundary overwrite pending; last wins.
//   - At the boundary, if pend=1: shadow<=pending, pend<=0, and disp_ack pulses
//     in the same cycle as frame_tick.
//   - If disp_load is high in the boundary cycle itself, that cycle's inputs go
//     straight into shadow (they win over older pending). pend is cleared and
//     disp_ack pulses.
//   - No pending data at the boundary: shadow is unchanged and disp_ack=0.
// - Shadow never changes between boundaries, so each frame displays one
//   coherent value.
// TESTING
//   Use REFRESH_DIV=8 and BLANK_CYCLES=2 throughout.
//   1. Reset, then run 40 cycles with no load.
//      -> selectn stays 4'hF and sseg_digit stays 7'h7F throughout.
//      -> frame_tick pulses at cycle 32 after release.
//   2. Load value=16'h1234, dp=4'b0001, blank=0 before the first boundary.
//      -> disp_ack coincides with frame_tick.
//      -> Next frame shows digit0 selectn=4'hE, digit=7'h19, dp=0.
//      -> digit3 shows selectn=4'h7, digit=7'h79, dp=1.
//      -> Each digit is lit 6 cycles and dark 2 cycles.
//   3. Two loads before one boundary (16'hAAAA, then 16'h5555).
//      -> Only 5555 is displayed ('5' = 7'h12), with a single disp_ack.
//   4. Load 16'hF00D exactly in the boundary cycle while pending holds 16'h1111.
//      -> Shadow becomes F00D immediately, disp_ack pulses once, and a later
//         boundary gives no ack.
//   5. Set blank=4'b0100 with value 16'h8888.
//      -> selectn never shows 4'hB; other digits show 7'h00.
//   6. Assert rst mid-DRIVE on digit 2.
//      -> Outputs go to reset values the same cycle, the display goes dark, and
//         the pending load is lost (no ack after release).

Source files
------------

// File: rtl/sseg_mux_driver.sv
// Time-multiplexed driver for a 4-digit common-anode seven-segment display.
// Loads are staged in a pending register and applied only at frame boundaries.
module sseg_mux_driver #(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_disp_value,
    input  logic [3:0]  i_disp_dp,
    input  logic [3:0]  i_disp_blank,
    input  logic        i_disp_load,
    output logic        o_disp_ack,
    output logic        o_frame_tick,
    output logic [6:0]  o_sseg_digit,
    output logic        o_sseg_dp,
    output logic [3:0]  o_sseg_selectn
);

    localparam int unsigned CntW = $clog2(REFRESH_DIV);

    typedef enum logic {StBlank, StDrive} state_t;

    state_t            r_state, w_state_d;
    logic [CntW-1:0]   r_cnt, w_cnt_d;
    logic [1:0]        r_idx, w_idx_d;

    logic [15:0]       r_pend_value, r_shadow_value, w_shadow_value_d;
    logic [3:0]        r_pend_dp, r_shadow_dp, w_shadow_dp_d;
    logic [3:0]        r_pend_blank, r_shadow_blank, w_shadow_blank_d;
    logic              r_pend;

    logic              w_cnt_end, w_blank_end, w_boundary;
    logic [3:0]        w_nibble;
    logic [3:0]        w_sel_d;
    logic [6:0]        w_seg_d;
    logic              w_dp_d;

    logic              r_disp_ack, r_frame_tick, r_sseg_dp;
    logic [6:0]        r_sseg_digit;
    logic [3:0]        r_sseg_selectn;

    function automatic logic [6:0] f_decode(input logic [3:0] i_nib);
        logic [6:0] seg;
        seg = 7'h7F;
        case (i_nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

    assign w_cnt_end   = (r_cnt == CntW'(REFRESH_DIV - 1));
    assign w_blank_end = (r_cnt == CntW'(BLANK_CYCLES - 1));
    assign w_boundary  = w_cnt_end && (r_idx == 2'd3);

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt + 1'b1;
        w_idx_d   = r_idx;
        if (w_cnt_end) begin
            w_cnt_d   = '0;
            w_idx_d   = r_idx + 2'd1;
            w_state_d = StBlank;
        end else if (r_state == StBlank && w_blank_end) begin
            w_state_d = StDrive;
        end
    end

    // A load in the boundary cycle itself bypasses the pending register.
    always_comb begin
        w_shadow_value_d = r_shadow_value;
        w_shadow_dp_d    = r_shadow_dp;
        w_shadow_blank_d = r_shadow_blank;
        if (w_boundary) begin
            if (i_disp_load) begin
                w_shadow_value_d = i_disp_value;
                w_shadow_dp_d    = i_disp_dp;
                w_shadow_blank_d = i_disp_blank;
            end else if (r_pend) begin
                w_shadow_value_d = r_pend_value;
                w_shadow_dp_d    = r_pend_dp;
                w_shadow_blank_d = r_pend_blank;
            end
        end
    end

    // Shadow never changes on a DRIVE entry edge, so reading r_shadow_* here is safe.
    always_comb begin
        w_nibble = r_shadow_value[{w_idx_d, 2'b00} +: 4];
        w_sel_d  = 4'hF;
        w_seg_d  = 7'h7F;
        w_dp_d   = 1'b1;
        if (w_state_d == StDrive && !r_shadow_blank[w_idx_d]) begin
            w_sel_d = ~(4'b0001 << w_idx_d);
            w_seg_d = f_decode(w_nibble);
            w_dp_d  = ~r_shadow_dp[w_idx_d];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state        <= StBlank;
            r_cnt          <= '0;
            r_idx          <= 2'd0;
            r_pend         <= 1'b0;
            r_pend_value   <= 16'h0000;
            r_pend_dp      <= 4'h0;
            r_pend_blank   <= 4'h0;
            r_shadow_value <= 16'h0000;
            r_shadow_dp    <= 4'h0;
            r_shadow_blank <= 4'hF;
            r_disp_ack     <= 1'b0;
            r_frame_tick   <= 1'b0;
            r_sseg_digit   <= 7'h7F;
            r_sseg_dp      <= 1'b1;
            r_sseg_selectn <= 4'hF;
        end else begin
            r_state        <= w_state_d;
            r_cnt          <= w_cnt_d;
            r_idx          <= w_idx_d;
            r_shadow_value <= w_shadow_value_d;
            r_shadow_dp    <= w_shadow_dp_d;
            r_shadow_blank <= w_shadow_blank_d;
            if (w_boundary) begin
                r_pend <= 1'b0;
            end else if (i_disp_load) begin
                r_pend       <= 1'b1;
                r_pend_value <= i_disp_value;
                r_pend_dp    <= i_disp_dp;
                r_pend_blank <= i_disp_blank;
            end
            r_disp_ack     <= w_boundary && (r_pend || i_disp_load);
            r_frame_tick   <= w_boundary;
            r_sseg_digit   <= w_seg_d;
            r_sseg_dp      <= w_dp_d;
            r_sseg_selectn <= w_sel_d;
        end
    end

    assign o_disp_ack     = r_disp_ack;
    assign o_frame_tick   = r_frame_tick;
    assign o_sseg_digit   = r_sseg_digit;
    assign o_sseg_dp      = r_sseg_dp;
    assign o_sseg_selectn = r_sseg_selectn;

endmodule

// File: tb/tb_sseg_mux_driver.sv
// Directed bench for sseg_mux_driver with REFRESH_DIV=8, BLANK_CYCLES=2:
// 8-cycle slots, 2 dark + 6 lit, 32-cycle frames.
module tb_sseg_mux_driver;

    logic        clk;
    logic        rst;
    logic [15:0] disp_value;
    logic [3:0]  disp_dp;
    logic [3:0]  disp_blank;
    logic        disp_load;
    logic        disp_ack;
    logic        frame_tick;
    logic [6:0]  sseg_digit;
    logic        sseg_dp;
    logic [3:0]  sseg_selectn;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Expected displayed contents, and what the next boundary should apply.
    logic [15:0] exp_value, nxt_value;
    logic [3:0]  exp_dp, nxt_dp, exp_blank, nxt_blank;
    logic        ack_due;

    sseg_mux_driver #(
        .REFRESH_DIV  (8),
        .BLANK_CYCLES (2)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_disp_value   (disp_value),
        .i_disp_dp      (disp_dp),
        .i_disp_blank   (disp_blank),
        .i_disp_load    (disp_load),
        .o_disp_ack     (disp_ack),
        .o_frame_tick   (frame_tick),
        .o_sseg_digit   (sseg_digit),
        .o_sseg_dp      (sseg_dp),
        .o_sseg_selectn (sseg_selectn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, got, exp);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " selectn"}, 32'(sseg_selectn), 32'hF);
        chk({tag, " digit"},   32'(sseg_digit),   32'h7F);
        chk({tag, " dp"},      32'(sseg_dp),      32'h1);
        chk({tag, " ack"},     32'(disp_ack),     32'h0);
        chk({tag, " tick"},    32'(frame_tick),   32'h0);
    endtask

    // Advance n cycles; after edge k since release the slot counter is k%8 and digit (k/8)%4.
    task automatic run(input int n);
        int         cnt;
        int         idx;
        logic       bnd;
        logic [3:0] e_sel;
        logic [6:0] e_seg;
        logic       e_dp;
        logic [3:0] nib;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            cnt   = cyc % 8;
            idx   = (cyc / 8) % 4;
            bnd   = (cyc % 32 == 0);
            e_sel = 4'hF;
            e_seg = 7'h7F;
            e_dp  = 1'b1;
            if (cnt >= 2 && !exp_blank[idx]) begin
                nib   = exp_value[idx*4 +: 4];
                e_sel = ~(4'b0001 << idx);
                e_seg = seg_of(nib);
                e_dp  = ~exp_dp[idx];
            end
            chk("selectn", 32'(sseg_selectn), 32'(e_sel));
            chk("digit",   32'(sseg_digit),   32'(e_seg));
            chk("dp",      32'(sseg_dp),      32'(e_dp));
            chk("frame_tick", 32'(frame_tick), 32'(bnd));
            chk("disp_ack",   32'(disp_ack),   32'(bnd && ack_due));
            if (bnd) begin
                if (ack_due) begin
                    exp_value = nxt_value;
                    exp_dp    = nxt_dp;
                    exp_blank = nxt_blank;
                end
                ack_due = 1'b0;
            end
        end
    endtask

    task automatic load_tick(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl);
        disp_value = v;
        disp_dp    = dp;
        disp_blank = bl;
        disp_load  = 1'b1;
        nxt_value  = v;
        nxt_dp     = dp;
        nxt_blank  = bl;
        ack_due    = 1'b1;
        run(1);
        disp_load  = 1'b0;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst       = 1'b0;
        cyc       = 0;
        exp_value = 16'h0000;
        exp_dp    = 4'h0;
        exp_blank = 4'hF;
        ack_due   = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        disp_value = 16'h0000;
        disp_dp    = 4'h0;
        disp_blank = 4'h0;
        disp_load  = 1'b0;
        nxt_value  = 16'h0000;
        nxt_dp     = 4'h0;
        nxt_blank  = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        release_reset();

        // 1: dark display, first frame_tick at cycle 32, no ack
        run(40);

        // 2: load 1234, ack with tick at 64, frame 64..96 shows it
        load_tick(16'h1234, 4'b0001, 4'b0000);
        run(55);

        // 3: AAAA then 5555 before boundary 128; only 5555 shown, single ack
        load_tick(16'hAAAA, 4'b0000, 4'b0000);
        run(3);
        load_tick(16'h5555, 4'b0000, 4'b0000);
        run(59);

        // 4: pending 1111, then F00D in boundary cycle 192; boundary 224 gives no ack
        load_tick(16'h1111, 4'b0000, 4'b0000);
        run(30);
        load_tick(16'hF00D, 4'b1000, 4'b0000);
        run(64);

        // 5: digit 2 blanked
        load_tick(16'h8888, 4'b0000, 4'b0100);
        run(63);

        // 6: reset mid-DRIVE on digit 2 with a load pending
        load_tick(16'h4321, 4'b0000, 4'b0000);
        run(31);
        load_tick(16'h9999, 4'b0010, 4'b0000);
        run(19);
        chk("pre-reset digit2 selectn", 32'(sseg_selectn), 32'hB);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("async reset");
        release_reset();
        run(40);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
